async_fifo_write_ctrl: RTL and testbench

Write-domain controller for the async FIFO. It shares the single FIFO write port between two requesters (NoC input ports) with round-robin arbitration. It owns the binary and Gray write pointers and drives the dual-port memory write strobe and address. It derives full, almost-full and a conservative fill level from the read pointer after the two-flop synchronizer.

---
 rtl/async_fifo_defs_pkg.sv | 12 +
 rtl/gray_to_binary.sv | 14 +
 rtl/async_fifo_write_ctrl.sv | 118 +++++++++++
 tb/tb_async_fifo_write_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/async_fifo_defs_pkg.sv
// Shared async-FIFO definitions used by the write controller, the read controller
// and the pointer synchronizers.
package async_fifo_defs;

  localparam int ADDRESS_SIZE = 4;
  localparam int PTR_WIDTH    = ADDRESS_SIZE + 1;
  localparam int DEPTH        = 1 << ADDRESS_SIZE;

  localparam logic REQ0_IDX = 1'b0;
  localparam logic REQ1_IDX = 1'b1;

endpackage

// File: rtl/gray_to_binary.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of all Gray
// bits at and above it. Shared by the read and write controllers.
module gray_to_binary #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] binary
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign binary[i] = ^gray[WIDTH-1:i];
  end

endmodule

// File: rtl/async_fifo_write_ctrl.sv
// Write-domain controller of the async FIFO: round-robin arbitration between two
// requesters, binary/Gray write pointers and full/almost-full/fill-level flags.
module async_fifo_write_ctrl
  import async_fifo_defs::*;
#(
  parameter int ADDRESS_SIZE      = async_fifo_defs::ADDRESS_SIZE,
  parameter int DATA_WIDTH        = 32,
  parameter int ALMOST_FULL_LEVEL = 12
) (
  input  logic                    write_clk,
  input  logic                    write_reset,
  input  logic                    req0_valid,
  input  logic [DATA_WIDTH-1:0]   req0_data,
  output logic                    req0_ready,
  input  logic                    req1_valid,
  input  logic [DATA_WIDTH-1:0]   req1_data,
  output logic                    req1_ready,
  input  logic [ADDRESS_SIZE:0]   synchronized_read_pointer2,
  output logic [ADDRESS_SIZE:0]   write_pointer,
  output logic                    mem_write_en,
  output logic [ADDRESS_SIZE-1:0] mem_write_addr,
  output logic [DATA_WIDTH-1:0]   mem_write_data,
  output logic                    full,
  output logic                    almost_full,
  output logic [ADDRESS_SIZE:0]   fill_level,
  output logic                    last_grant
);

  localparam int PW = ADDRESS_SIZE + 1;

  logic [PW-1:0] wbin_r;
  logic [PW-1:0] wgray_r;
  logic          full_r;
  logic          almost_full_r;
  logic [PW-1:0] fill_level_r;
  logic          last_grant_r;

  logic          grant_s;
  logic          grant_idx_s;
  logic [PW-1:0] wbin_next_s;
  logic [PW-1:0] wgray_next_s;
  logic [PW-1:0] rbin_s;
  logic [PW-1:0] full_match_s;
  logic [PW-1:0] fill_next_s;

  gray_to_binary #(.WIDTH(PW)) u_rptr_g2b (
    .gray   (synchronized_read_pointer2),
    .binary (rbin_s)
  );

  // Round-robin arbiter; index defaults to req1 so the data mux idles on req1_data
  always_comb begin
    grant_s     = 1'b0;
    grant_idx_s = REQ1_IDX;
    if (full_r) begin
      grant_s     = 1'b0;
      grant_idx_s = REQ1_IDX;
    end else if (req0_valid && req1_valid) begin
      grant_s     = 1'b1;
      grant_idx_s = ~last_grant_r;
    end else if (req0_valid) begin
      grant_s     = 1'b1;
      grant_idx_s = REQ0_IDX;
    end else if (req1_valid) begin
      grant_s     = 1'b1;
      grant_idx_s = REQ1_IDX;
    end else begin
      grant_s     = 1'b0;
      grant_idx_s = REQ1_IDX;
    end
  end

  // Next pointers and flag terms; flags see this cycle's accept with no lag
  always_comb begin
    wbin_next_s  = wbin_r;
    if (grant_s) begin
      wbin_next_s = wbin_r + PW'(1);
    end else begin
      wbin_next_s = wbin_r;
    end
    wgray_next_s = wbin_next_s ^ (wbin_next_s >> 1);
    full_match_s = {~synchronized_read_pointer2[PW-1:PW-2], synchronized_read_pointer2[PW-3:0]};
    fill_next_s  = wbin_next_s - rbin_s;
  end

  // Pointer, flag and last-grant state
  always_ff @(posedge write_clk or posedge write_reset) begin
    if (write_reset) begin
      wbin_r        <= '0;
      wgray_r       <= '0;
      full_r        <= 1'b0;
      almost_full_r <= 1'b0;
      fill_level_r  <= '0;
      last_grant_r  <= REQ1_IDX;
    end else begin
      wbin_r        <= wbin_next_s;
      wgray_r       <= wgray_next_s;
      full_r        <= (wgray_next_s == full_match_s);
      almost_full_r <= (fill_next_s >= PW'(ALMOST_FULL_LEVEL));
      fill_level_r  <= fill_next_s;
      if (grant_s) begin
        last_grant_r <= grant_idx_s;
      end
    end
  end

  assign req0_ready     = grant_s & (grant_idx_s == REQ0_IDX);
  assign req1_ready     = grant_s & (grant_idx_s == REQ1_IDX);
  assign mem_write_en   = grant_s;
  assign mem_write_addr = wbin_r[ADDRESS_SIZE-1:0];
  assign mem_write_data = (grant_idx_s == REQ0_IDX) ? req0_data : req1_data;
  assign write_pointer  = wgray_r;
  assign full           = full_r;
  assign almost_full    = almost_full_r;
  assign fill_level     = fill_level_r;
  assign last_grant     = last_grant_r;

endmodule

// File: tb/tb_async_fifo_write_ctrl.sv
// Directed bench for async_fifo_write_ctrl: reset, round-robin, fill, unfull,
// pointer wrap-around and reset in the middle of a burst.
module tb_async_fifo_write_ctrl;

  logic        write_clk = 1'b0;
  logic        write_reset;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic [4:0]  synchronized_read_pointer2;
  logic [4:0]  write_pointer;
  logic        mem_write_en;
  logic [3:0]  mem_write_addr;
  logic [31:0] mem_write_data;
  logic        full, almost_full;
  logic [4:0]  fill_level;
  logic        last_grant;

  int vectors = 0;
  int miscompares = 0;
  logic [4:0] prev_wp;
  logic [4:0] tmp5;

  always #5 write_clk = ~write_clk;

  async_fifo_write_ctrl #(.ADDRESS_SIZE(4), .DATA_WIDTH(32), .ALMOST_FULL_LEVEL(12)) dut (
    .write_clk                  (write_clk),
    .write_reset                (write_reset),
    .req0_valid                 (req0_valid),
    .req0_data                  (req0_data),
    .req0_ready                 (req0_ready),
    .req1_valid                 (req1_valid),
    .req1_data                  (req1_data),
    .req1_ready                 (req1_ready),
    .synchronized_read_pointer2 (synchronized_read_pointer2),
    .write_pointer              (write_pointer),
    .mem_write_en               (mem_write_en),
    .mem_write_addr             (mem_write_addr),
    .mem_write_data             (mem_write_data),
    .full                       (full),
    .almost_full                (almost_full),
    .fill_level                 (fill_level),
    .last_grant                 (last_grant)
  );

  function automatic logic [4:0] b2g(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_pulse();
    @(negedge write_clk);
    write_reset = 1'b1;
    #1;
    @(negedge write_clk);
    write_reset = 1'b0;
  endtask

  initial begin
    write_reset = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_data = 32'hAAAA_0000;
    req1_data = 32'hBBBB_1111;
    synchronized_read_pointer2 = 5'd0;

    // Reset asserted mid-cycle
    #3 write_reset = 1'b1;
    #1;
    chk("rst_wp", 32'(write_pointer), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_af", 32'(almost_full), 32'd0);
    chk("rst_fill", 32'(fill_level), 32'd0);
    chk("rst_lg", 32'(last_grant), 32'd1);
    chk("rst_rdy0", 32'(req0_ready), 32'd0);
    chk("rst_rdy1", 32'(req1_ready), 32'd0);
    chk("rst_wen", 32'(mem_write_en), 32'd0);
    chk("rst_addr", 32'(mem_write_addr), 32'd0);
    chk("rst_data", mem_write_data, 32'hBBBB_1111);
    @(negedge write_clk);
    write_reset = 1'b0;

    // Round-robin with both requesters valid
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge write_clk);
      req0_data = 32'd100 + 32'(i);
      req1_data = 32'd200 + 32'(i);
      #1;
      chk("rr_rdy0", 32'(req0_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_rdy1", 32'(req1_ready), (i % 2 == 0) ? 32'd0 : 32'd1);
      chk("rr_data", mem_write_data, (i % 2 == 0) ? 32'd100 + 32'(i) : 32'd200 + 32'(i));
      chk("rr_addr", 32'(mem_write_addr), 32'(i));
      @(posedge write_clk);
      #1;
      chk("rr_lg", 32'(last_grant), (i % 2 == 0) ? 32'd0 : 32'd1);
      tmp5 = 5'(i + 1);
      chk("rr_wp", 32'(write_pointer), 32'(b2g(tmp5)));
    end
    chk("rr_fill", 32'(fill_level), 32'd6);

    // Fill from empty with req0 only
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    reset_pulse();
    req0_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge write_clk);
      req0_data = 32'h5000 + 32'(i);
      #1;
      chk("fill_rdy0", 32'(req0_ready), 32'd1);
      chk("fill_addr", 32'(mem_write_addr), 32'(i));
      @(posedge write_clk);
      #1;
      chk("fill_af", 32'(almost_full), (i + 1 >= 12) ? 32'd1 : 32'd0);
      chk("fill_full", 32'(full), (i == 15) ? 32'd1 : 32'd0);
      chk("fill_lvl", 32'(fill_level), 32'(i + 1));
    end
    chk("fill_wp", 32'(write_pointer), 32'b11000);
    req1_valid = 1'b1;
    #1;
    chk("full_rdy0", 32'(req0_ready), 32'd0);
    chk("full_rdy1", 32'(req1_ready), 32'd0);
    chk("full_wen", 32'(mem_write_en), 32'd0);
    @(posedge write_clk);
    #1;
    chk("full_hold_wp", 32'(write_pointer), 32'b11000);
    chk("full_hold_lvl", 32'(fill_level), 32'd16);

    // Unfull: one read frees one slot; last grant was req0 so req1 wins
    @(negedge write_clk);
    synchronized_read_pointer2 = 5'b00001;
    #1;
    chk("unf_rdy_pre", 32'(req0_ready | req1_ready), 32'd0);
    @(posedge write_clk);
    #1;
    chk("unf_full0", 32'(full), 32'd0);
    chk("unf_lvl", 32'(fill_level), 32'd15);
    chk("unf_rdy1", 32'(req1_ready), 32'd1);
    chk("unf_rdy0", 32'(req0_ready), 32'd0);
    chk("unf_addr", 32'(mem_write_addr), 32'd0);
    @(posedge write_clk);
    #1;
    chk("unf_full1", 32'(full), 32'd1);
    chk("unf_wp", 32'(write_pointer), 32'b11001);
    chk("unf_lg", 32'(last_grant), 32'd1);
    chk("unf_rdy_post", 32'(req0_ready | req1_ready), 32'd0);

    // Wrap-around with the read pointer trailing by two entries
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    synchronized_read_pointer2 = 5'd0;
    reset_pulse();
    req0_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (i > 0) @(negedge write_clk);
      tmp5 = (i >= 2) ? 5'(i - 2) : 5'd0;
      synchronized_read_pointer2 = b2g(tmp5);
      #1;
      chk("wrap_wen", 32'(mem_write_en), 32'd1);
      chk("wrap_addr", 32'(mem_write_addr), 32'(i % 16));
      prev_wp = write_pointer;
      @(posedge write_clk);
      #1;
      tmp5 = 5'(i + 1);
      chk("wrap_wp", 32'(write_pointer), 32'(b2g(tmp5)));
      chk("wrap_1bit", 32'($countones(write_pointer ^ prev_wp)), 32'd1);
      chk("wrap_nofull", 32'(full), 32'd0);
      chk("wrap_lvl_le3", 32'(fill_level <= 5'd3), 32'd1);
    end

    // Reset pulse in the middle of a req1 burst
    req0_valid = 1'b0;
    synchronized_read_pointer2 = 5'd0;
    reset_pulse();
    req1_valid = 1'b1;
    repeat (5) @(posedge write_clk);
    #1;
    chk("mid_wp5", 32'(write_pointer), 32'b00111);
    @(negedge write_clk);
    write_reset = 1'b1;
    #1;
    chk("mid_wp0", 32'(write_pointer), 32'd0);
    chk("mid_fill0", 32'(fill_level), 32'd0);
    chk("mid_addr0", 32'(mem_write_addr), 32'd0);
    @(negedge write_clk);
    write_reset = 1'b0;
    #1;
    chk("mid_rdy1", 32'(req1_ready), 32'd1);
    chk("mid_first_addr", 32'(mem_write_addr), 32'd0);
    @(posedge write_clk);
    #1;
    chk("mid_wp1", 32'(write_pointer), 32'b00001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
